// File: rtl/video_wr_ctrl.sv
// video_wr_ctrl
//   Write-side sequencer between the video input pipeline and video_wr_buffer.
//   Frames the incoming beat stream into AXI bursts (command + tagged data with
//   last), and rotates frames across a ring of DDR frame buffers, skipping the
//   one the reader currently owns.
//
// Ports
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_frame_start            one-cycle pulse, new frame begins
//   i_data_vld/i_data        input beat
//   i_data_last              final beat of the frame (qualified by i_data_vld)
//   i_rd_frame_idx           frame index currently owned by the reader
//   o_wr_buff_req_en         burst command strobe (coincides with burst last beat)
//   o_wr_buff_burst_len      awlen (beats-1)
//   o_wr_buff_addr           burst start byte address
//   o_wr_buff_vld/data/last  data beat, last beat of the burst
//   o_wr_frame_idx           frame being written
//   o_done_frame_idx         most recently completed frame
//   o_frame_done             one-cycle pulse, frame complete
//   o_frame_err              sticky, frame start seen mid-frame
module video_wr_ctrl #(
    parameter int                  AXI_DATA_WIDTH  = 128,
    parameter int                  AXI_ADDR_WIDTH  = 32,
    parameter int                  BURST_LEN       = 64,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_SIZE      = 32'h0080_0000,
    parameter int                  FRAME_NUM       = 3
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_frame_start,
    input  logic                      i_data_vld,
    input  logic [AXI_DATA_WIDTH-1:0] i_data,
    input  logic                      i_data_last,
    input  logic [1:0]                i_rd_frame_idx,
    output logic                      o_wr_buff_req_en,
    output logic [7:0]                o_wr_buff_burst_len,
    output logic [AXI_ADDR_WIDTH-1:0] o_wr_buff_addr,
    output logic                      o_wr_buff_vld,
    output logic [AXI_DATA_WIDTH-1:0] o_wr_buff_data,
    output logic                      o_wr_buff_data_last,
    output logic [1:0]                o_wr_frame_idx,
    output logic [1:0]                o_done_frame_idx,
    output logic                      o_frame_done,
    output logic                      o_frame_err
);

    localparam logic [AXI_ADDR_WIDTH-1:0] BPB      = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);
    localparam logic [8:0]                CNT_MAX  = 9'(BURST_LEN - 1);
    localparam logic [1:0]                LAST_IDX = 2'(FRAME_NUM - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                    state, state_nxt;
    logic [8:0]                cnt;
    logic [AXI_ADDR_WIDTH-1:0] burst_addr;
    logic [AXI_ADDR_WIDTH-1:0] frame_addr;
    logic [AXI_ADDR_WIDTH-1:0] burst_bytes;
    logic [1:0]                idx_inc, idx_sel;
    logic                      burst_close;
    logic                      done_pend;

    function automatic logic [1:0] inc_idx(input logic [1:0] i);
        return (i == LAST_IDX) ? 2'd0 : i + 2'd1;
    endfunction

    // Next frame in the ring; hop over the reader's frame. With at least
    // three buffers one hop always lands on a free frame.
    always_comb begin
        idx_inc     = inc_idx(o_wr_frame_idx);
        idx_sel     = (idx_inc == i_rd_frame_idx) ? inc_idx(idx_inc) : idx_inc;
        frame_addr  = FRAME_BASE_ADDR + AXI_ADDR_WIDTH'(idx_sel) * FRAME_SIZE;
        burst_bytes = (AXI_ADDR_WIDTH'(cnt) + 1'b1) * BPB;
        burst_close = i_data_vld && (cnt == CNT_MAX || i_data_last);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_frame_start)             state_nxt = WRITE;
            WRITE:   if (i_data_vld && i_data_last) state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt                 <= '0;
            burst_addr          <= '0;
            done_pend           <= 1'b0;
            o_wr_buff_req_en    <= 1'b0;
            o_wr_buff_burst_len <= '0;
            o_wr_buff_addr      <= '0;
            o_wr_buff_vld       <= 1'b0;
            o_wr_buff_data      <= '0;
            o_wr_buff_data_last <= 1'b0;
            o_wr_frame_idx      <= '0;
            o_done_frame_idx    <= '0;
            o_frame_done        <= 1'b0;
            o_frame_err         <= 1'b0;
        end else begin
            o_wr_buff_vld       <= 1'b0;
            o_wr_buff_req_en    <= 1'b0;
            o_wr_buff_data_last <= 1'b0;
            // Frame completion is reported one cycle behind the final last beat.
            done_pend           <= 1'b0;
            o_frame_done        <= done_pend;
            if (done_pend) o_done_frame_idx <= o_wr_frame_idx;

            case (state)
                IDLE: begin
                    // Beats arriving here (including one alongside the start
                    // pulse) are dropped.
                    if (i_frame_start) begin
                        o_wr_frame_idx <= idx_sel;
                        burst_addr     <= frame_addr;
                        cnt            <= '0;
                    end
                end
                WRITE: begin
                    if (i_frame_start) o_frame_err <= 1'b1;
                    if (i_data_vld) begin
                        o_wr_buff_vld  <= 1'b1;
                        o_wr_buff_data <= i_data;
                        cnt            <= cnt + 9'd1;
                        if (burst_close) begin
                            o_wr_buff_data_last <= 1'b1;
                            o_wr_buff_req_en    <= 1'b1;
                            o_wr_buff_burst_len <= cnt[7:0];
                            o_wr_buff_addr      <= burst_addr;
                            burst_addr          <= burst_addr + burst_bytes;
                            cnt                 <= '0;
                            if (i_data_last) done_pend <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_video_wr_ctrl.sv
// Randomized bench for video_wr_ctrl. A transaction-level model predicts the
// beat, command and frame-done streams (with their cycle of appearance); a
// negedge monitor compares the DUT's streams against those queues.
module tb_video_wr_ctrl;

    localparam int BL = 4;
    localparam int FN = 3;
    localparam int FS = 'h1000;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_frame_start;
    logic         i_data_vld;
    logic [127:0] i_data;
    logic         i_data_last;
    logic [1:0]   i_rd_frame_idx;
    logic         o_wr_buff_req_en;
    logic [7:0]   o_wr_buff_burst_len;
    logic [31:0]  o_wr_buff_addr;
    logic         o_wr_buff_vld;
    logic [127:0] o_wr_buff_data;
    logic         o_wr_buff_data_last;
    logic [1:0]   o_wr_frame_idx;
    logic [1:0]   o_done_frame_idx;
    logic         o_frame_done;
    logic         o_frame_err;

    video_wr_ctrl #(
        .AXI_DATA_WIDTH (128),
        .AXI_ADDR_WIDTH (32),
        .BURST_LEN      (BL),
        .FRAME_BASE_ADDR(32'h0000_0000),
        .FRAME_SIZE     (32'h0000_1000),
        .FRAME_NUM      (FN)
    ) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_frame_start      (i_frame_start),
        .i_data_vld         (i_data_vld),
        .i_data             (i_data),
        .i_data_last        (i_data_last),
        .i_rd_frame_idx     (i_rd_frame_idx),
        .o_wr_buff_req_en   (o_wr_buff_req_en),
        .o_wr_buff_burst_len(o_wr_buff_burst_len),
        .o_wr_buff_addr     (o_wr_buff_addr),
        .o_wr_buff_vld      (o_wr_buff_vld),
        .o_wr_buff_data     (o_wr_buff_data),
        .o_wr_buff_data_last(o_wr_buff_data_last),
        .o_wr_frame_idx     (o_wr_frame_idx),
        .o_done_frame_idx   (o_done_frame_idx),
        .o_frame_done       (o_frame_done),
        .o_frame_err        (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct { logic [127:0] d; logic last; int cyc; } beat_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } cmd_t;
    typedef struct { logic [1:0] idx; int cyc; } done_t;

    beat_t bq[$];
    cmd_t  cq[$];
    done_t dq[$];

    // Reference model state
    int m_wr = 0;
    bit m_in = 0;
    int m_bi = 0;
    int m_base = 0;
    bit m_err = 0;

    // ---------------- monitor ----------------
    beat_t mb;
    cmd_t  mc;
    done_t md;
    always @(negedge i_clk) begin
        if (o_wr_buff_vld === 1'b1) begin
            if (bq.size() == 0) chk("beat_unexpected", 128'(1), 128'(0));
            else begin
                mb = bq.pop_front();
                chk("beat_data", o_wr_buff_data, mb.d);
                chk("beat_last", 128'(o_wr_buff_data_last), 128'(mb.last));
                chk("beat_cycle", 128'(cyc), 128'(mb.cyc));
            end
        end
        if (o_wr_buff_data_last === 1'b1 || o_wr_buff_req_en === 1'b1)
            chk("req_with_last", 128'(o_wr_buff_req_en & o_wr_buff_data_last & o_wr_buff_vld), 128'(1));
        if (o_wr_buff_req_en === 1'b1) begin
            if (cq.size() == 0) chk("cmd_unexpected", 128'(1), 128'(0));
            else begin
                mc = cq.pop_front();
                chk("cmd_addr", 128'(o_wr_buff_addr), 128'(mc.addr));
                chk("cmd_len", 128'(o_wr_buff_burst_len), 128'(mc.len));
            end
        end
        if (o_frame_done === 1'b1) begin
            if (dq.size() == 0) chk("done_unexpected", 128'(1), 128'(0));
            else begin
                md = dq.pop_front();
                chk("done_idx", 128'(o_done_frame_idx), 128'(md.idx));
                chk("done_cycle", 128'(cyc), 128'(md.cyc));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_in();
        i_frame_start = 1'b0;
        i_data_vld    = 1'b0;
        i_data_last   = 1'b0;
    endtask

    task automatic idle_cyc();
        clr_in();
        step();
    endtask

    task automatic start_frame(input logic [1:0] rd, input bit with_beat);
        int nxt;
        i_frame_start  = 1'b1;
        i_rd_frame_idx = rd;
        i_data_vld     = with_beat;
        i_data_last    = 1'b0;
        i_data         = {$urandom, $urandom, $urandom, $urandom};
        if (!m_in) begin
            nxt = (m_wr + 1) % FN;
            if (nxt == int'(rd)) nxt = (nxt + 1) % FN;
            m_wr   = nxt;
            m_base = nxt * FS;
            m_in   = 1;
            m_bi   = 0;
        end else begin
            m_err = 1;
        end
        step();
        clr_in();
    endtask

    task automatic beat(input bit last);
        int p;
        bit bl;
        i_data_vld  = 1'b1;
        i_data_last = last;
        i_data      = {$urandom, $urandom, $urandom, $urandom};
        if (m_in) begin
            p  = m_bi % BL;
            bl = (p == BL - 1) || last;
            bq.push_back('{d: i_data, last: bl, cyc: cyc + 1});
            if (bl) cq.push_back('{addr: 32'(m_base + (m_bi - p) * 16), len: 8'(p)});
            m_bi++;
            if (last) begin
                dq.push_back('{idx: 2'(m_wr), cyc: cyc + 2});
                m_in = 0;
            end
        end
        step();
        clr_in();
    endtask

    task automatic frame(input int n, input logic [1:0] rd, input bit gaps);
        start_frame(rd, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle_cyc();
            beat(i == n - 1);
        end
        idle_cyc();
        idle_cyc();
    endtask

    task automatic do_reset();
        clr_in();
        i_reset = 1'b1;
        step();
        chk("rst_vld", 128'(o_wr_buff_vld), 128'(0));
        chk("rst_req", 128'(o_wr_buff_req_en), 128'(0));
        chk("rst_len", 128'(o_wr_buff_burst_len), 128'(0));
        chk("rst_addr", 128'(o_wr_buff_addr), 128'(0));
        chk("rst_data", o_wr_buff_data, 128'(0));
        chk("rst_last", 128'(o_wr_buff_data_last), 128'(0));
        chk("rst_wr_idx", 128'(o_wr_frame_idx), 128'(0));
        chk("rst_done_idx", 128'(o_done_frame_idx), 128'(0));
        chk("rst_done", 128'(o_frame_done), 128'(0));
        chk("rst_err", 128'(o_frame_err), 128'(0));
        m_wr = 0; m_in = 0; m_bi = 0; m_err = 0;
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset        = 1'b1;
        i_data         = '0;
        i_rd_frame_idx = 2'd0;
        clr_in();
        step();
        do_reset();
        idle_cyc();

        // Full bursts: frame 1, commands 0x1000 / 0x1040
        frame(8, 2'd0, 1'b0);
        chk("full_wr_idx", 128'(o_wr_frame_idx), 128'(1));
        chk("full_done_idx", 128'(o_done_frame_idx), 128'(1));

        // Partial final burst: frame 2, lengths 3 then 1
        frame(6, 2'd0, 1'b0);

        // Single-beat frame: 0 would be next but reader owns it -> frame 1
        frame(1, 2'd0, 1'b0);
        chk("single_wr_idx", 128'(o_wr_frame_idx), 128'(1));

        // Reader skip: writer at 1, reader at 2 -> frame 0 @ 0x0000
        start_frame(2'd2, 1'b0);
        chk("skip_wr_idx", 128'(o_wr_frame_idx), 128'(0));
        for (int i = 0; i < 5; i++) beat(i == 4);
        idle_cyc();
        idle_cyc();

        // Misuse: beats in IDLE dropped, start with a beat drops that beat,
        // mid-frame start flags an error but the frame carries on.
        beat(1'b0);
        beat(1'b1);
        idle_cyc();
        start_frame(2'd3, 1'b1);
        beat(1'b0);
        beat(1'b0);
        start_frame(2'd0, 1'b0);
        chk("midframe_err", 128'(o_frame_err), 128'(m_err));
        chk("midframe_idx", 128'(o_wr_frame_idx), 128'(m_wr));
        for (int i = 0; i < 4; i++) beat(i == 3);
        idle_cyc();
        idle_cyc();
        chk("err_sticky", 128'(o_frame_err), 128'(1));

        // Reset mid-burst: two beats of four, then reset; restart at frame 1
        start_frame(2'd2, 1'b0);
        beat(1'b0);
        beat(1'b0);
        do_reset();
        idle_cyc();
        frame(4, 2'd0, 1'b0);
        chk("rst_restart_idx", 128'(o_wr_frame_idx), 128'(1));

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            frame($urandom_range(1, 11), 2'($urandom_range(0, 3)), 1'b1);
            if ($urandom_range(0, 1) == 1) beat(1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 4; i++) idle_cyc();
        chk("beat_q_drained", 128'(bq.size()), 128'(0));
        chk("cmd_q_drained", 128'(cq.size()), 128'(0));
        chk("done_q_drained", 128'(dq.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
